mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits between the pipeline CPU's instruction cache and data cache and one shared 128-bit block memory.
- Lets a single unified memory serve both cache miss paths in the pipeline top level.
- Arbitrates block read/write requests round-robin, runs one memory transaction at a time with a busywait handshake on both sides, and returns the read block to the winning cache.
- Contains a watchdog that terminates a transaction the memory never completes.

Parameters:
ADDR_WIDTH, 28, block address width (byte address >> 4)
BLOCK_WIDTH, 128, data block width in bits
TIMEOUT_CYCLES, 64, cycles in BUSY before the watchdog aborts a transaction (must be >= 2)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
I_READ  input  1  I-cache block read request, held until its busywait drops
I_ADDRESS  input  ADDR_WIDTH  I-cache block address
I_READDATA  output  BLOCK_WIDTH  block returned to I-cache
I_BUSYWAIT  output  1  I-cache stall
D_READ  input  1  D-cache block read request
D_WRITE  input  1  D-cache block write request (write-back)
D_ADDRESS  input  ADDR_WIDTH  D-cache block address
D_WRITEDATA  input  BLOCK_WIDTH  D-cache write block
D_READDATA  output  BLOCK_WIDTH  block returned to D-cache
D_BUSYWAIT  output  1  D-cache stall
MEM_READ  output  1  memory read strobe
MEM_WRITE  output  1  memory write strobe
MEM_ADDRESS  output  ADDR_WIDTH  memory block address
MEM_WRITEDATA  output  BLOCK_WIDTH  memory write block
MEM_READDATA  input  BLOCK_WIDTH  memory read block
MEM_BUSYWAIT  input  1  memory busy
GRANT_D  output  1  1 = current/last grant is D-cache, 0 = I-cache
TIMEOUT_ERR  output  1  sticky watchdog flag

Behaviour:
- Reset (RESET=0, asynchronous, takes effect immediately):
  - state=IDLE; MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, I_READDATA, D_READDATA, TIMEOUT_ERR = 0.
  - last_grant=I, so D wins the first tie; GRANT_D=0.
- Reset mid-transaction: strobes drop immediately, the transaction is abandoned, and no DONE is produced.
- Request definitions: i_req = I_READ; d_req = D_READ | D_WRITE. D_READ and D_WRITE both high is treated as a write.
- Busywait outputs (combinational):
  - I_BUSYWAIT = i_req & ~(state==DONE & GRANT_D==0).
  - D_BUSYWAIT = d_req & ~(state==DONE & GRANT_D==1).
  - A new request therefore stalls the requester in the same cycle it is raised.
- FSM, state IDLE:
  - If exactly one request is present, grant it.
  - If both are present, grant the requester not served last (round-robin).
  - On the grant edge: latch the op, address and writedata into MEM_*; set GRANT_D; clear seen_busy and wdog; go to BUSY.
  - MEM_READ/MEM_WRITE rise 1 cycle after the request is first sampled.
- FSM, state BUSY:
  - Strobes and address are held constant; wdog increments each cycle.
  - MEM_BUSYWAIT=1 sets seen_busy.
  - Completion is seen_busy & MEM_BUSYWAIT==0. On completion: for reads, latch MEM_READDATA into the granted requester's READDATA register (the other READDATA is unchanged); drop strobes; update last_grant; go to DONE.
  - If wdog reaches TIMEOUT_CYCLES-1 without completion: set TIMEOUT_ERR (sticky until reset), load READDATA with 0, drop strobes, go to DONE.
- FSM, state DONE:
  - Exactly one cycle; the granted busywait is low for that cycle.
  - Always go to IDLE, even if the requester keeps its request high. A still-high request is re-arbitrated as a new one.
- Minimum transaction is 4 cycles: IDLE-grant, BUSY (busy seen), BUSY (complete), DONE.
- A request withdrawn while in BUSY is not aborted: the transaction completes, and DONE occurs with no visible effect.
- The ungranted requester stays stalled throughout. Its inputs are sampled only at its own grant.
- READDATA registers are valid from the DONE cycle and hold until the next completion for that requester.

Test Plan:
- Reset, then I_READ=1, I_ADDRESS=0x0000010; memory busy for 5 cycles returns 0xAAAA…AA → MEM_READ rises 1 cycle after the request; I_BUSYWAIT low for exactly one cycle; I_READDATA=0xAAAA…AA; GRANT_D=0.
- D_WRITE=1, D_ADDRESS=0x0000003, D_WRITEDATA=0x1234…; → MEM_WRITE=1 with MEM_WRITEDATA=0x1234… held stable until completion; D_READDATA unchanged; D_BUSYWAIT drops one cycle.
- I_READ and D_READ raised in the same cycle after reset → D is served first (GRANT_D=1), then I is granted the cycle after D's DONE. Both raised again → I first (round-robin).
- MEM_BUSYWAIT tied high, TIMEOUT_CYCLES=8 → TIMEOUT_ERR=1 at BUSY cycle 8; READDATA=0; the requester is released; TIMEOUT_ERR stays 1 across later good transactions.
- RESET pulsed low mid-BUSY → MEM_READ/MEM_WRITE go 0 asynchronously; after release, the still-held request is re-granted from IDLE and completes normally.
- D_READ dropped during BUSY → the memory read still completes; D_READDATA is updated; no stall of a subsequent I_READ beyond the normal 4-cycle minimum.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block memory between the I-cache and D-cache miss paths.
// One memory transaction at a time, with busywait handshakes on both sides and a watchdog.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 28,
  parameter int BLOCK_WIDTH    = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_READ,
  input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] I_READDATA,
  output logic                   I_BUSYWAIT,
  input  logic                   D_READ,
  input  logic                   D_WRITE,
  input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] D_READDATA,
  output logic                   D_BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT,
  output logic                   GRANT_D,
  output logic                   TIMEOUT_ERR
);

  localparam int WDOG_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant_d;
  logic                  seen_busy;
  logic [WDOG_WIDTH-1:0] wdog;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic complete;

  assign i_req  = I_READ;
  assign d_req  = D_READ | D_WRITE;
  // On a tie the side that was not served last wins.
  assign pick_d = d_req & (~i_req | ~last_grant_d);

  // Completion needs a busy phase first, so a stale low busywait cannot end a transaction early.
  assign complete = seen_busy & ~MEM_BUSYWAIT;

  assign I_BUSYWAIT = i_req & ~((state == DONE) & ~GRANT_D);
  assign D_BUSYWAIT = d_req & ~((state == DONE) &  GRANT_D);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      last_grant_d  <= 1'b0;
      seen_busy     <= 1'b0;
      wdog          <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA    <= '0;
      D_READDATA    <= '0;
      GRANT_D       <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            GRANT_D   <= pick_d;
            seen_busy <= 1'b0;
            wdog      <= '0;
            state     <= BUSY;
            if (pick_d) begin
              // Read and write together is a write-back.
              MEM_WRITE     <= D_WRITE;
              MEM_READ      <= ~D_WRITE;
              MEM_ADDRESS   <= D_ADDRESS;
              MEM_WRITEDATA <= D_WRITEDATA;
            end else begin
              MEM_WRITE   <= 1'b0;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= I_ADDRESS;
            end
          end
        end

        BUSY: begin
          if (MEM_BUSYWAIT) begin
            seen_busy <= 1'b1;
          end
          if (complete) begin
            if (MEM_READ) begin
              if (GRANT_D) begin
                D_READDATA <= MEM_READDATA;
              end else begin
                I_READDATA <= MEM_READDATA;
              end
            end
            MEM_READ     <= 1'b0;
            MEM_WRITE    <= 1'b0;
            last_grant_d <= GRANT_D;
            state        <= DONE;
          end else if (wdog == WDOG_LIMIT) begin
            // The memory never answered: release the requester with an all-zero block.
            TIMEOUT_ERR <= 1'b1;
            if (GRANT_D) begin
              D_READDATA <= '0;
            end else begin
              I_READDATA <= '0;
            end
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            state     <= DONE;
          end else begin
            wdog <= wdog + WDOG_WIDTH'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single transactions plus
// hand-written sequences for ties, watchdog, mid-transaction reset and withdrawn requests.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int BW = 128;

  logic          CLK;
  logic          RESET;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [BW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ;
  logic          D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [BW-1:0] D_WRITEDATA;
  logic [BW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [BW-1:0] MEM_WRITEDATA;
  logic [BW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;
  logic          GRANT_D;
  logic          TIMEOUT_ERR;

  int tests;
  int failures;

  // Memory model: busy for mem_latency cycles after a strobe appears, then idle.
  int            mem_latency;
  int            mem_cnt;
  logic          force_busy;
  logic [BW-1:0] mem_rdata;

  assign MEM_READDATA = mem_rdata;
  assign MEM_BUSYWAIT = force_busy | ((MEM_READ | MEM_WRITE) & (mem_cnt != 0));

  always @(posedge CLK) begin
    if (!(MEM_READ || MEM_WRITE)) mem_cnt <= mem_latency;
    else if (mem_cnt != 0)        mem_cnt <= mem_cnt - 1;
  end

  mem_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .BLOCK_WIDTH   (BW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .I_READ       (I_READ),
    .I_ADDRESS    (I_ADDRESS),
    .I_READDATA   (I_READDATA),
    .I_BUSYWAIT   (I_BUSYWAIT),
    .D_READ       (D_READ),
    .D_WRITE      (D_WRITE),
    .D_ADDRESS    (D_ADDRESS),
    .D_WRITEDATA  (D_WRITEDATA),
    .D_READDATA   (D_READDATA),
    .D_BUSYWAIT   (D_BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .GRANT_D      (GRANT_D),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    int            lat;
    int            exp_cycles;
    logic [BW-1:0] exp_i_rd;
    logic [BW-1:0] exp_d_rd;
  } vec_t;

  function automatic vec_t mkVec(input logic is_d, input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                                 input logic [BW-1:0] rdata, input int lat, input int exp_cycles,
                                 input logic [BW-1:0] exp_i_rd, input logic [BW-1:0] exp_d_rd);
    vec_t v;
    v.is_d = is_d; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.lat = lat; v.exp_cycles = exp_cycles; v.exp_i_rd = exp_i_rd; v.exp_d_rd = exp_d_rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic busyOf(input logic is_d);
    return is_d ? D_BUSYWAIT : I_BUSYWAIT;
  endfunction

  // Counts negedges until the selected busywait drops, giving up after 40.
  task automatic waitDone(input logic is_d, output int cycles);
    cycles = 0;
    while (busyOf(is_d) && cycles < 40) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  // Runs one transaction from an idle arbiter; called on a negedge.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   cycles;
    logic exp_wr;
    exp_wr      = v.is_d & v.wr;
    mem_rdata   = v.rdata;
    mem_latency = v.lat;
    if (v.is_d) begin
      D_READ = v.rd; D_WRITE = v.wr; D_ADDRESS = v.addr; D_WRITEDATA = v.wdata;
    end else begin
      I_READ = 1'b1; I_ADDRESS = v.addr;
    end
    #1;
    checkFlag($sformatf("%s_stall_now", tag), busyOf(v.is_d), 1'b1);
    checkFlag($sformatf("%s_no_early_strobe", tag), MEM_READ | MEM_WRITE, 1'b0);
    @(negedge CLK);
    checkFlag($sformatf("%s_mem_write", tag), MEM_WRITE, exp_wr);
    checkFlag($sformatf("%s_mem_read", tag), MEM_READ, ~exp_wr);
    checkOutput($sformatf("%s_mem_addr", tag), BW'(MEM_ADDRESS), BW'(v.addr));
    checkFlag($sformatf("%s_grant_d", tag), GRANT_D, v.is_d);
    if (exp_wr) checkOutput($sformatf("%s_wdata", tag), MEM_WRITEDATA, v.wdata);
    waitDone(v.is_d, cycles);
    checkCount($sformatf("%s_latency", tag), cycles + 1, v.exp_cycles);
    if (exp_wr) checkOutput($sformatf("%s_wdata_held", tag), MEM_WRITEDATA, v.wdata);
    checkOutput($sformatf("%s_i_readdata", tag), I_READDATA, v.exp_i_rd);
    checkOutput($sformatf("%s_d_readdata", tag), D_READDATA, v.exp_d_rd);
    @(negedge CLK);
    checkFlag($sformatf("%s_release_one_cycle", tag), busyOf(v.is_d), 1'b1);
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
  endtask

  task automatic pulseReset();
    RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  localparam logic [BW-1:0] AA   = {16{8'hAA}};
  localparam logic [BW-1:0] P55  = {16{8'h55}};
  localparam logic [BW-1:0] DEAD = {4{32'hDEADBEEF}};

  vec_t vecs[5];

  initial begin
    int cycles;
    tests = 0; failures = 0;
    RESET = 1'b0; force_busy = 1'b0; mem_latency = 1; mem_rdata = '0;
    I_READ = 1'b0; I_ADDRESS = '0; D_READ = 1'b0; D_WRITE = 1'b0;
    D_ADDRESS = '0; D_WRITEDATA = '0;

    vecs[0] = mkVec(1'b0, 1'b1, 1'b0, 28'h0000010, '0, AA, 5, 7, AA, '0);
    vecs[1] = mkVec(1'b1, 1'b0, 1'b1, 28'h0000003, {8{16'h1234}}, '0, 3, 5, AA, '0);
    vecs[2] = mkVec(1'b1, 1'b1, 1'b0, 28'h0ABCDEF, '0, P55, 1, 3, AA, P55);
    vecs[3] = mkVec(1'b0, 1'b1, 1'b0, 28'hFFFFFFF, '0, DEAD, 2, 4, DEAD, P55);
    vecs[4] = mkVec(1'b1, 1'b1, 1'b1, 28'h1000000, {4{32'hCAFEF00D}}, {16{8'hEE}}, 2, 4, DEAD, P55);

    @(negedge CLK);
    @(negedge CLK);
    checkFlag("reset_mem_read", MEM_READ, 1'b0);
    checkFlag("reset_mem_write", MEM_WRITE, 1'b0);
    checkOutput("reset_mem_addr", BW'(MEM_ADDRESS), '0);
    checkOutput("reset_i_readdata", I_READDATA, '0);
    checkOutput("reset_d_readdata", D_READDATA, '0);
    checkFlag("reset_grant_d", GRANT_D, 1'b0);
    checkFlag("reset_timeout", TIMEOUT_ERR, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    checkFlag("idle_i_busy", I_BUSYWAIT, 1'b0);
    checkFlag("idle_d_busy", D_BUSYWAIT, 1'b0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k], $sformatf("vec%0d", k));
    end

    // Tie straight after reset: D first, then the held I request.
    pulseReset();
    mem_latency = 1; mem_rdata = {16{8'h11}};
    I_READ = 1'b1; I_ADDRESS = 28'h0000011; D_READ = 1'b1; D_ADDRESS = 28'h0000022;
    @(negedge CLK);
    checkFlag("tie1_grant_d", GRANT_D, 1'b1);
    checkOutput("tie1_d_addr", BW'(MEM_ADDRESS), BW'(28'h0000022));
    waitDone(1'b1, cycles);
    checkCount("tie1_d_latency", cycles + 1, 3);
    checkOutput("tie1_d_data", D_READDATA, {16{8'h11}});
    checkFlag("tie1_i_stalled", I_BUSYWAIT, 1'b1);
    D_READ = 1'b0; mem_rdata = {16{8'h22}};
    @(negedge CLK);
    checkFlag("tie1_idle_gap", MEM_READ, 1'b0);
    @(negedge CLK);
    checkFlag("tie1_i_grant", GRANT_D, 1'b0);
    checkFlag("tie1_i_strobe", MEM_READ, 1'b1);
    checkOutput("tie1_i_addr", BW'(MEM_ADDRESS), BW'(28'h0000011));
    waitDone(1'b0, cycles);
    checkCount("tie1_i_latency", cycles, 2);
    checkOutput("tie1_i_data", I_READDATA, {16{8'h22}});
    I_READ = 1'b0;
    @(negedge CLK);

    // D served alone, so the next tie must go to I.
    applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 28'h0000033, '0, {16{8'h33}}, 1, 3,
                        {16{8'h22}}, {16{8'h33}}), "rr_d");
    mem_latency = 1; mem_rdata = {16{8'h44}};
    I_READ = 1'b1; I_ADDRESS = 28'h0000044; D_READ = 1'b1; D_ADDRESS = 28'h0000045;
    @(negedge CLK);
    checkFlag("tie2_grant_i", GRANT_D, 1'b0);
    checkOutput("tie2_i_addr", BW'(MEM_ADDRESS), BW'(28'h0000044));
    waitDone(1'b0, cycles);
    checkCount("tie2_i_latency", cycles + 1, 3);
    checkOutput("tie2_i_data", I_READDATA, {16{8'h44}});
    checkFlag("tie2_d_stalled", D_BUSYWAIT, 1'b1);
    I_READ = 1'b0; D_READ = 1'b0;
    @(negedge CLK);

    // Watchdog: memory never goes idle.
    force_busy = 1'b1; mem_rdata = {16{8'h77}};
    I_READ = 1'b1; I_ADDRESS = 28'h0000005;
    repeat (8) @(negedge CLK);
    checkFlag("wdog_not_yet", TIMEOUT_ERR, 1'b0);
    checkFlag("wdog_still_stalled", I_BUSYWAIT, 1'b1);
    @(negedge CLK);
    checkFlag("wdog_released", I_BUSYWAIT, 1'b0);
    checkFlag("wdog_err", TIMEOUT_ERR, 1'b1);
    checkOutput("wdog_zero_data", I_READDATA, '0);
    I_READ = 1'b0; force_busy = 1'b0;
    @(negedge CLK);
    applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 28'h0000056, '0, P55, 2, 4, '0, P55), "post_wdog");
    checkFlag("wdog_sticky", TIMEOUT_ERR, 1'b1);

    // Reset in the middle of a write, request held across it.
    mem_latency = 5;
    D_WRITE = 1'b1; D_ADDRESS = 28'h0000077; D_WRITEDATA = {16{8'h66}};
    @(negedge CLK);
    @(negedge CLK);
    checkFlag("mid_reset_pre", MEM_WRITE, 1'b1);
    RESET = 1'b0;
    #1;
    checkFlag("mid_reset_write_drop", MEM_WRITE, 1'b0);
    checkFlag("mid_reset_read_drop", MEM_READ, 1'b0);
    checkFlag("mid_reset_timeout_clr", TIMEOUT_ERR, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checkFlag("mid_reset_regrant", MEM_WRITE, 1'b1);
    checkOutput("mid_reset_wdata", MEM_WRITEDATA, {16{8'h66}});
    waitDone(1'b1, cycles);
    checkCount("mid_reset_latency", cycles + 1, 7);
    checkOutput("mid_reset_d_data", D_READDATA, '0);
    D_WRITE = 1'b0;
    @(negedge CLK);

    // D_READ withdrawn during BUSY: the read still lands in D_READDATA.
    mem_latency = 3; mem_rdata = {16{8'h99}};
    D_READ = 1'b1; D_ADDRESS = 28'h0000042;
    @(negedge CLK);
    checkFlag("drop_strobe", MEM_READ, 1'b1);
    @(negedge CLK);
    D_READ = 1'b0;
    #1;
    checkFlag("drop_no_stall", D_BUSYWAIT, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    checkFlag("drop_still_busy", MEM_READ, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    checkFlag("drop_finished", MEM_READ, 1'b0);
    checkOutput("drop_d_data", D_READDATA, {16{8'h99}});
    applyStimulus(mkVec(1'b0, 1'b1, 1'b0, 28'h00000BB, '0, {16{8'hBB}}, 1, 3,
                        {16{8'hBB}}, {16{8'h99}}), "after_drop");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
